// File: rtl/divn_pkg.sv
// Shared constants, mode enum and divisor decode for the divide_by_n clock-enable divider.
package divn_pkg;

    localparam int DIVN_WIDTH     = 8;
    localparam int DIVN_DIV_RESET = 100;

    typedef enum logic {
        DIVN_FREE    = 1'b0,
        DIVN_ONESHOT = 1'b1
    } divn_mode_e;

    // Encoded divisor 0 stands for 2^width.
    function automatic logic [31:0] divn_decode(input logic [31:0] enc, input int width);
        return (enc == 32'd0) ? (32'd1 << width) : enc;
    endfunction

endpackage

// File: rtl/divn_shadow_reg.sv
// Pending-divisor register: captures div_val on div_load, applies it to div_cur when apply is high.
import divn_pkg::*;

module divn_shadow_reg #(
    parameter int WIDTH     = DIVN_WIDTH,
    parameter int DIV_RESET = DIVN_DIV_RESET
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_val,
    input  logic             apply,
    output logic             div_busy,
    output logic [WIDTH-1:0] div_cur
);

    logic [WIDTH-1:0] pending;

    // A load coinciding with apply bypasses the pending register entirely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            div_busy <= 1'b0;
            div_cur  <= WIDTH'(DIV_RESET);
        end else if (apply) begin
            div_busy <= 1'b0;
            if (div_load) begin
                div_cur <= div_val;
            end else if (div_busy) begin
                div_cur <= pending;
            end
        end else if (div_load) begin
            pending  <= div_val;
            div_busy <= 1'b1;
        end
    end

endmodule

// File: rtl/divide_by_n.sv
// Runtime-programmable clock-enable divider with one-shot mode and shadow-loaded divisor.
// Optional square-wave output enabled by defining DIVN_SQUARE_EN.
import divn_pkg::*;

module divide_by_n #(
    parameter int WIDTH     = DIVN_WIDTH,
    parameter int DIV_RESET = DIVN_DIV_RESET
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             clr,
    input  logic             oneshot,
    input  logic [WIDTH-1:0] div_val,
    input  logic             div_load,
    output logic             div_busy,
    output logic [WIDTH-1:0] div_cur,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done
`ifdef DIVN_SQUARE_EN
    ,
    output logic             sq_out
`endif
);

    divn_mode_e       mode;
    logic [WIDTH-1:0] last;
    logic             wrap;
    logic             idle;
    logic             apply;

    assign mode  = oneshot ? DIVN_ONESHOT : DIVN_FREE;
    // D-1 in WIDTH bits; encoded 0 (2^WIDTH) yields all ones.
    assign last  = WIDTH'(divn_decode(32'(div_cur), WIDTH) - 32'd1);
    assign wrap  = ena && !done && !clr && (count == last);
    assign idle  = (count == '0) && !ena;
    assign apply = wrap || clr || idle;

    divn_shadow_reg #(
        .WIDTH     (WIDTH),
        .DIV_RESET (DIV_RESET)
    ) u_shadow (
        .clk      (clk),
        .rst_n    (rst_n),
        .div_load (div_load),
        .div_val  (div_val),
        .apply    (apply),
        .div_busy (div_busy),
        .div_cur  (div_cur)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else if (clr) begin
            count <= '0;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else if (wrap) begin
            count <= '0;
            tc    <= 1'b1;
            if (mode == DIVN_ONESHOT) begin
                done <= 1'b1;
            end
        end else begin
            tc <= 1'b0;
            if (ena && !done) begin
                count <= count + 1'b1;
            end
        end
    end

`ifdef DIVN_SQUARE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq_out <= 1'b0;
        end else if (clr) begin
            sq_out <= 1'b0;
        end else if (wrap) begin
            sq_out <= !sq_out;
        end
    end
`endif

endmodule

// File: tb/tb_divide_by_n.sv
// Scoreboard bench for divide_by_n: stimulus queues expected tc edge numbers, a monitor pops and compares.
module tb_divide_by_n;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena, clr, oneshot, div_load;
    logic [7:0] div_val;
    logic       div_busy, tc, done;
    logic [7:0] div_cur, count;

    logic       ena4, clr4, oneshot4, div_load4;
    logic [3:0] div_val4;
    logic       div_busy4, tc4, done4;
    logic [3:0] div_cur4, count4;

`ifdef DIVN_SQUARE_EN
    logic sq_out, sq_out4;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int q8[$];
    int q4[$];

    divide_by_n #(.WIDTH(8), .DIV_RESET(100)) u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr), .oneshot(oneshot),
        .div_val(div_val), .div_load(div_load), .div_busy(div_busy),
        .div_cur(div_cur), .count(count), .tc(tc), .done(done)
`ifdef DIVN_SQUARE_EN
        , .sq_out(sq_out)
`endif
    );

    divide_by_n #(.WIDTH(4), .DIV_RESET(5)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena4), .clr(clr4), .oneshot(oneshot4),
        .div_val(div_val4), .div_load(div_load4), .div_busy(div_busy4),
        .div_cur(div_cur4), .count(count4), .tc(tc4), .done(done4)
`ifdef DIVN_SQUARE_EN
        , .sq_out(sq_out4)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // tc seen at the falling edge after wrap edge e must match the oldest queued e.
    always @(negedge clk) begin
        if (rst_n) begin
            while (q8.size() > 0 && q8[0] < cyc) begin
                checks++; errors++;
                $display("FAIL tc8_missing: got no tc expected tc at edge %0d", q8.pop_front());
            end
            if (tc) begin
                checks++;
                if (q8.size() == 0) begin
                    errors++;
                    $display("FAIL tc8_unexpected: got tc at edge %0d expected none", cyc);
                end else if (q8[0] != cyc) begin
                    errors++;
                    $display("FAIL tc8_edge: got tc at edge %0d expected edge %0d", cyc, q8[0]);
                end else begin
                    void'(q8.pop_front());
                end
            end
            while (q4.size() > 0 && q4[0] < cyc) begin
                checks++; errors++;
                $display("FAIL tc4_missing: got no tc expected tc at edge %0d", q4.pop_front());
            end
            if (tc4) begin
                checks++;
                if (q4.size() == 0) begin
                    errors++;
                    $display("FAIL tc4_unexpected: got tc at edge %0d expected none", cyc);
                end else if (q4[0] != cyc) begin
                    errors++;
                    $display("FAIL tc4_edge: got tc at edge %0d expected edge %0d", cyc, q4[0]);
                end else begin
                    void'(q4.pop_front());
                end
            end
        end
    end

    initial begin
        int c;
        rst_n = 1'b0; ena = 0; clr = 0; oneshot = 0; div_load = 0; div_val = '0;
        ena4 = 0; clr4 = 0; oneshot4 = 0; div_load4 = 0; div_val4 = '0;
        wait_neg(3);
        chk("rst_count", count, 0);
        chk("rst_tc", tc, 0);
        chk("rst_div_cur", div_cur, 100);
        chk("rst_busy", div_busy, 0);
        chk("rst_done", done, 0);
        chk("rst_div_cur4", div_cur4, 5);
        rst_n = 1'b1;
        wait_neg(1);

        // Free-run with reset divisor 100.
        c = cyc; ena = 1;
        q8.push_back(c + 100); q8.push_back(c + 200); q8.push_back(c + 300);
        for (int k = 0; k < 3; k++) begin
            wait_neg(99);
            chk("count_99", count, 99);
            wait_neg(1);
        end
        chk("count_wrap0", count, 0);
        ena = 0;

        // Idle load of 10 applies directly.
        div_val = 8'd10; div_load = 1;
        wait_neg(1);
        div_load = 0;
        chk("idle_load_cur", div_cur, 10);
        chk("idle_load_busy", div_busy, 0);

        // ena gap of 7 stretches the period to 17; then shadow loads 5 then 4.
        c = cyc; ena = 1;
        q8.push_back(c + 17); q8.push_back(c + 27); q8.push_back(c + 31); q8.push_back(c + 35);
        wait_neg(4);
        chk("gap_count", count, 4);
        ena = 0;
        wait_neg(7);
        chk("gap_hold", count, 4);
        ena = 1;
        wait_neg(6);
        wait_neg(3);
        chk("load_at3", count, 3);
        div_val = 8'd5; div_load = 1;
        wait_neg(1);
        div_load = 0;
        chk("busy_set", div_busy, 1);
        chk("cur_unchanged", div_cur, 10);
        wait_neg(1);
        div_val = 8'd4; div_load = 1;
        wait_neg(1);
        div_load = 0;
        wait_neg(3);
        chk("pre_wrap_count", count, 9);
        chk("pre_wrap_busy", div_busy, 1);
        wait_neg(1);
        chk("applied_busy", div_busy, 0);
        chk("applied_cur", div_cur, 4);
        wait_neg(8);
        ena = 0;

        // One-shot with D=3.
        div_val = 8'd3; div_load = 1; oneshot = 1;
        wait_neg(1);
        div_load = 0;
        chk("os_cur", div_cur, 3);
        c = cyc; ena = 1;
        q8.push_back(c + 3);
        wait_neg(3);
        chk("os_done", done, 1);
        chk("os_count", count, 0);
        wait_neg(5);
        chk("os_done_hold", done, 1);
        chk("os_count_hold", count, 0);
        clr = 1; oneshot = 0;
        wait_neg(1);
        clr = 0;
        chk("clr_done", done, 0);
        chk("clr_count", count, 0);
        c = cyc;
        q8.push_back(c + 3); q8.push_back(c + 6);
        wait_neg(2);
        chk("resume_count", count, 2);
        wait_neg(4);
        wait_neg(1);
        chk("pre_clr_count", count, 1);
        clr = 1;
        wait_neg(1);
        clr = 0;
        chk("clr_ena_count", count, 0);
        chk("clr_ena_tc", tc, 0);
        c = cyc;
        q8.push_back(c + 3);
        wait_neg(3);
        ena = 0;

        // D=1: tc after every enabled edge.
        div_val = 8'd1; div_load = 1;
        wait_neg(1);
        div_load = 0;
        chk("d1_cur", div_cur, 1);
        c = cyc; ena = 1;
        for (int k = 1; k <= 4; k++) q8.push_back(c + k);
        wait_neg(4);
        chk("d1_count", count, 0);
        ena = 0;

        // WIDTH=4, encoded divisor 0 -> period 16.
        div_val4 = 4'd0; div_load4 = 1;
        wait_neg(1);
        div_load4 = 0;
        chk("w4_cur", div_cur4, 0);
        c = cyc; ena4 = 1;
        q4.push_back(c + 16); q4.push_back(c + 32);
        wait_neg(15);
        chk("w4_count15", count4, 15);
        wait_neg(17);
        ena4 = 0;

        // Reset mid-count with a divisor pending.
        div_val = 8'd10; div_load = 1;
        wait_neg(1);
        div_load = 0;
        ena = 1;
        wait_neg(4);
        chk("mid_count", count, 4);
        div_val = 8'd7; div_load = 1;
        wait_neg(1);
        div_load = 0;
        chk("mid_busy", div_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_tc", tc, 0);
        chk("arst_div_cur", div_cur, 100);
        chk("arst_busy", div_busy, 0);
        chk("arst_done", done, 0);
        chk("arst_div_cur4", div_cur4, 5);
        ena = 0;
        wait_neg(2);
        rst_n = 1'b1;
        wait_neg(3);
        chk("post_rst_busy", div_busy, 0);
        chk("post_rst_cur", div_cur, 100);

        chk("q8_drained", q8.size(), 0);
        chk("q4_drained", q4.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
